tennis_game: RTL and testbench



---
 rtl/tennis_game.sv | 195 +++++++++++++++++++
 tb/tb_tennis_game.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/tennis_game.sv
// Two-player LED tennis core: a one-hot ball bounces across 16 LEDs, each
// player returns it from their end LED, scores are scanned onto two 7-seg digits.
module tennis_game #(
  parameter int unsigned TICK_DIV   = 25_000_000,
  parameter int unsigned SCAN_DIV   = 100_000,
  parameter int unsigned WIN_POINTS = 7,
  parameter int unsigned HOLD_TICKS = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rightplayer,
  input  logic        leftplayer,
  output logic [15:0] light,
  output logic [7:0]  AN_Out,
  output logic [6:0]  C_Out
);

  localparam int unsigned TW = (TICK_DIV > 1)   ? $clog2(TICK_DIV)   : 1;
  localparam int unsigned SW = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
  localparam int unsigned HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  typedef enum logic [2:0] {
    SERVE_R,
    SERVE_L,
    MOVE_L,
    MOVE_R,
    POINT,
    GAMEOVER
  } state_t;

  state_t        state, state_n;
  logic [3:0]    pos, pos_n;
  logic [3:0]    score_r, score_r_n;
  logic [3:0]    score_l, score_l_n;
  logic [HW-1:0] hold, hold_n;
  logic          left_won, left_won_n;

  logic r_s1, r_s2, r_prev, r_press;
  logic l_s1, l_s2, l_prev, l_press;

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [SW-1:0] scan_cnt;
  logic          digit_sel;

  logic [15:0]   light_n;
  logic [7:0]    an_n;
  logic [6:0]    seg_n;
  logic [3:0]    digit_val;

  // Press pulse is registered so it appears one cycle after the second sync flop.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_s1 <= 1'b0; r_s2 <= 1'b0; r_prev <= 1'b0; r_press <= 1'b0;
      l_s1 <= 1'b0; l_s2 <= 1'b0; l_prev <= 1'b0; l_press <= 1'b0;
    end else begin
      r_s1    <= rightplayer;
      r_s2    <= r_s1;
      r_prev  <= r_s2;
      r_press <= r_s2 & ~r_prev;
      l_s1    <= leftplayer;
      l_s2    <= l_s1;
      l_prev  <= l_s2;
      l_press <= l_s2 & ~l_prev;
    end
  end

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      tick_cnt  <= '0;
      scan_cnt  <= '0;
      digit_sel <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt  <= '0;
        digit_sel <= ~digit_sel;
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= SERVE_R;
      pos      <= '0;
      score_r  <= '0;
      score_l  <= '0;
      hold     <= '0;
      left_won <= 1'b0;
    end else begin
      state    <= state_n;
      pos      <= pos_n;
      score_r  <= score_r_n;
      score_l  <= score_l_n;
      hold     <= hold_n;
      left_won <= left_won_n;
    end
  end

  // A hit press at the end LED takes priority over a same-cycle tick there.
  always_comb begin
    state_n    = state;
    pos_n      = pos;
    score_r_n  = score_r;
    score_l_n  = score_l;
    hold_n     = hold;
    left_won_n = left_won;
    case (state)
      SERVE_R: begin
        pos_n = 4'd0;
        if (r_press) state_n = MOVE_L;
      end
      SERVE_L: begin
        pos_n = 4'd15;
        if (l_press) state_n = MOVE_R;
      end
      MOVE_L: begin
        if (l_press && pos == 4'd15) begin
          state_n = MOVE_R;
        end else if (l_press || (tick && pos == 4'd15)) begin
          score_r_n  = score_r + 4'd1;
          left_won_n = 1'b0;
          hold_n     = '0;
          state_n    = (score_r_n == 4'(WIN_POINTS)) ? GAMEOVER : POINT;
        end else if (tick) begin
          pos_n = pos + 4'd1;
        end
      end
      MOVE_R: begin
        if (r_press && pos == 4'd0) begin
          state_n = MOVE_L;
        end else if (r_press || (tick && pos == 4'd0)) begin
          score_l_n  = score_l + 4'd1;
          left_won_n = 1'b1;
          hold_n     = '0;
          state_n    = (score_l_n == 4'(WIN_POINTS)) ? GAMEOVER : POINT;
        end else if (tick) begin
          pos_n = pos - 4'd1;
        end
      end
      POINT: begin
        if (tick) begin
          if (hold == HW'(HOLD_TICKS - 1)) begin
            state_n = left_won ? SERVE_L : SERVE_R;
            pos_n   = left_won ? 4'd15 : 4'd0;
          end else begin
            hold_n = hold + HW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    light_n = '0;
    if (state_n == POINT || state_n == GAMEOVER) begin
      light_n = left_won_n ? 16'hFF00 : 16'h00FF;
    end else begin
      light_n[pos_n] = 1'b1;
    end
    an_n      = digit_sel ? 8'h7F : 8'hFE;
    digit_val = digit_sel ? score_l : score_r;
    case (digit_val)
      4'd0:    seg_n = 7'h40;
      4'd1:    seg_n = 7'h79;
      4'd2:    seg_n = 7'h24;
      4'd3:    seg_n = 7'h30;
      4'd4:    seg_n = 7'h19;
      4'd5:    seg_n = 7'h12;
      4'd6:    seg_n = 7'h02;
      4'd7:    seg_n = 7'h78;
      4'd8:    seg_n = 7'h00;
      4'd9:    seg_n = 7'h10;
      default: seg_n = 7'h7F;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      light  <= 16'h0001;
      AN_Out <= 8'hFE;
      C_Out  <= 7'h40;
    end else begin
      light  <= light_n;
      AN_Out <= an_n;
      C_Out  <= seg_n;
    end
  end

endmodule

// File: tb/tb_tennis_game.sv
// Directed bench for tennis_game: absolute-edge vector table for the rally,
// scoring and hold timing, plus display and reset sequences.
module tb_tennis_game;

  logic        clock = 1'b0;
  logic        reset;
  logic        rightplayer;
  logic        leftplayer;
  logic [15:0] light;
  logic [7:0]  AN_Out;
  logic [6:0]  C_Out;

  int unsigned cyc    = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic        rp;
    logic        lp;
    int unsigned at;
    logic [15:0] light;
  } vec_t;

  vec_t vecs[$];

  tennis_game #(
    .TICK_DIV  (4),
    .SCAN_DIV  (8),
    .WIN_POINTS(2),
    .HOLD_TICKS(2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rightplayer(rightplayer),
    .leftplayer (leftplayer),
    .light      (light),
    .AN_Out     (AN_Out),
    .C_Out      (C_Out)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    cyc++;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rp, input logic lp, input int unsigned at, input logic [15:0] l);
    vec_t v;
    v.rp = rp; v.lp = lp; v.at = at; v.light = l;
    vecs.push_back(v);
  endtask

  task automatic chk_digit(input logic [7:0] an, input logic [6:0] seg, input string name);
    int unsigned n = 0;
    while (AN_Out !== an && n < 40) begin
      step();
      n++;
    end
    chk({name, " anode"}, {24'h0, AN_Out}, {24'h0, an});
    chk({name, " seg"}, {25'h0, C_Out}, {25'h0, seg});
  endtask

  initial begin
    reset = 1'b0; rightplayer = 1'b0; leftplayer = 1'b0;

    // Edge numbers are absolute (edges 1-2 in reset); ticks fall after edges 5,9,13,...
    // so ball steps land on edges 6,10,14,...; a press driven after edge k acts at k+4.
    add(0, 0,   5, 16'h0001);
    add(1, 0,   8, 16'h0001);
    add(1, 0,   9, 16'h0001);
    add(1, 0,  10, 16'h0002);
    add(0, 0,  14, 16'h0004);
    for (int p = 3; p <= 15; p++) add(0, 0, 6 + 4 * p, 16'h0001 << p);
    add(1, 1,  69, 16'h8000);
    add(0, 0,  70, 16'h8000);
    add(0, 0,  74, 16'h4000);
    add(0, 0,  78, 16'h2000);
    add(0, 0,  82, 16'h1000);
    add(0, 0, 130, 16'h0001);
    add(0, 0, 133, 16'h0001);
    add(0, 0, 134, 16'hFF00);
    add(0, 1, 137, 16'hFF00);
    add(0, 0, 141, 16'hFF00);
    add(0, 0, 142, 16'h8000);
    add(1, 0, 147, 16'h8000);
    add(1, 1, 151, 16'h8000);
    add(0, 0, 154, 16'h4000);
    add(0, 0, 208, 16'h0002);
    add(1, 0, 210, 16'h0001);
    add(1, 0, 212, 16'h0001);
    add(0, 0, 214, 16'h0002);
    add(0, 0, 240, 16'h0080);
    add(0, 1, 243, 16'h0100);
    add(0, 1, 244, 16'h00FF);
    add(1, 0, 249, 16'h00FF);
    add(1, 0, 250, 16'h0001);
    add(1, 0, 258, 16'h0001);
    add(1, 1, 262, 16'h0001);
    add(1, 1, 270, 16'h0001);
    add(0, 0, 272, 16'h0001);
    add(1, 0, 276, 16'h0001);
    add(0, 0, 278, 16'h0002);
    add(0, 0, 334, 16'h8000);
    add(0, 0, 337, 16'h8000);
    add(0, 0, 338, 16'h00FF);
    add(1, 1, 350, 16'h00FF);
    add(0, 0, 360, 16'h00FF);
    add(1, 1, 380, 16'h00FF);

    step();
    step();
    chk("reset light", {16'h0, light}, 32'h0001);
    chk("reset anode", {24'h0, AN_Out}, 32'hFE);
    chk("reset seg", {25'h0, C_Out}, 32'h40);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      rightplayer = vecs[i].rp;
      leftplayer  = vecs[i].lp;
      while (cyc < vecs[i].at) step();
      chk($sformatf("vec%0d light @edge%0d", i, vecs[i].at), {16'h0, light}, {16'h0, vecs[i].light});
    end

    rightplayer = 1'b0; leftplayer = 1'b0;
    chk_digit(8'hFE, 7'h24, "gameover right score 2");
    chk_digit(8'h7F, 7'h79, "gameover left score 1");
    repeat (20) step();
    chk("gameover light held", {16'h0, light}, 32'h00FF);

    reset = 1'b0;
    step();
    step();
    chk("re-reset light", {16'h0, light}, 32'h0001);
    chk("re-reset anode", {24'h0, AN_Out}, 32'hFE);
    chk("re-reset seg", {25'h0, C_Out}, 32'h40);
    reset = 1'b1;
    chk_digit(8'h7F, 7'h40, "re-reset left score 0");
    chk_digit(8'hFE, 7'h40, "re-reset right score 0");
    repeat (12) step();
    chk("re-reset idle light", {16'h0, light}, 32'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
